// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for serial_adder
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_fulladder.sv
// fulladder: 1-bit full adder cell used as the serial adder's bit slice
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit add through one fulladder, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A-B via ~B and carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, work, b_ld;
  logic [CW-1:0]    cnt;
  logic             carry, c_ld, fa_s, fa_c;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~B : B;
  assign c_ld = sub | Cin;
`else
  assign b_ld = B;
  assign c_ld = Cin;
`endif
  fulladder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sh  <= A;
        b_sh  <= b_ld;
        carry <= c_ld;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      work  <= {fa_s, work[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      // carry still holds the carry into the MSB on the final bit
      if (cnt == CW'(WIDTH - 1)) begin
        S     <= {fa_s, work[WIDTH-1:1]};
        Cout  <= fa_c;
        V     <= carry ^ fa_c;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors against hand-computed sums for serial_adder (WIDTH=8)
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic       Cin = 1'b0;
  logic       sub = 1'b0;
  logic       busy, done, Cout, V;
  logic [7:0] S;
  int         vecs = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .S    (S),
    .Cout (Cout),
    .V    (V)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch at a negedge, then check done timing and results through E9.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sb, input logic [7:0] es, input logic ec, input logic ev);
    logic early;
    A = a; B = b; Cin = ci; sub = sb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_e0"}, busy, 1);
    early = done;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      early |= done;
    end
    chk({tag, "_early_done"}, early, 0);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_S"}, S, es);
    chk({tag, "_Cout"}, Cout, ec);
    chk({tag, "_V"}, V, ev);
    @(negedge clk);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    logic held;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", S, 0);
    chk("rst_Cout", Cout, 0);
    chk("rst_V", V, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    do_op("80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("3c_a5_c", 8'h3C, 8'hA5, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b0);
    // start held high: operands change during RUN, second op accepted at E10
    A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 8'h40; B = 8'h02;
    repeat (8) @(negedge clk);
    chk("held_done1", done, 1);
    chk("held_S1", S, 8'h33);
    @(negedge clk);
    chk("held_idle", busy, 0);
    @(negedge clk);
    chk("held_accept", busy, 1);
    start = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      held &= (S == 8'h33) && !done;
    end
    chk("held_S_during_run", held, 1);
    @(negedge clk);
    chk("held_done2", done, 1);
    chk("held_S2", S, 8'h42);
    @(negedge clk);
    // asynchronous reset mid-RUN after E4
    A = 8'h55; B = 8'h0A; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_S", S, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    held = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      held |= done | busy;
    end
    chk("mid_rst_no_done", held, 0);
    do_op("after_rst", 8'h55, 8'h0A, 1'b0, 1'b0, 8'h5F, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    do_op("sub_09_03", 8'h09, 8'h03, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial two's-complement adder that computes a WIDTH-bit sum one bit per clock through a single 1-bit `fulladder` cell. It sits directly upstream of that cell: it latches operands, feeds them LSB first with a registered carry, and collects the sum bits. This is the area-minimal alternative to a ripple-carry adder for datapaths that can accept WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand/result width in bits (legal range 2..32)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand A, sampled with accepted start
- B  input  WIDTH  operand B, sampled with accepted start
- Cin  input  1  carry-in, sampled with accepted start
- sub  input  1  subtract request, sampled with accepted start (present only with SERIAL_ADDER_SUB_EN)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- S  output  WIDTH  registered sum
- Cout  output  1  registered carry-out of MSB
- V  output  1  registered signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 -> load a_sh<=A, b_sh<=B (or ~B, see Configuration), carry<=Cin (or 1), bit counter<=0, go RUN. start=0 -> stay.
- RUN: each cycle the fulladder takes a_sh[0], b_sh[0], carry; sum bit shifted into work register from MSB side; a_sh/b_sh shift right; carry<=fulladder Cout; counter++.
- On the edge processing counter==WIDTH-1: S<=completed work register, Cout<=fulladder Cout, V<=carry XOR fulladder Cout, go DONE.
- DONE: done=1 for exactly one cycle, unconditionally -> IDLE.
- start while busy (RUN or DONE) ignored, not queued; A/B/Cin changes during RUN have no effect.
- S, Cout, V change only at completion; hold last result through subsequent operations until the next completion.
- Counter width $clog2(WIDTH); no wrap reachable since exit at WIDTH-1.

## Timing
- Reset (rst_n low, any time, asynchronous): state IDLE, busy=0, done=0, S=0, Cout=0, V=0, shift registers/carry/counter=0. Reset mid-RUN abandons the operation; S/Cout/V read 0, not partial.
- start sampled high at edge E0 -> busy high after E0; results and done valid after edge E(WIDTH); done low again after E(WIDTH+1), busy low together with done.
- Throughput: one operation per WIDTH+2 cycles when start held high continuously (accepted at E0, E(WIDTH+2), ...).
- All outputs registered; no combinational input-to-output paths.

## Configuration
- SERIAL_ADDER_SUB_EN defined: `sub` port exists; accepted start with sub=1 loads b_sh<=~B and carry<=1 (Cin ignored), producing A-B; Cout=1 means no borrow. sub=0 behaves as plain add.
- Not defined: no `sub` port; always A+B+Cin.

## Structure
- Package `serial_adder_pkg`: state enum typedef (IDLE, RUN, DONE), default WIDTH constant.
- One sub-module: existing `fulladder` instantiated once as the bit cell; all sequencing, shift registers and carry flop in serial_adder.

## Test plan
- WIDTH=8, A=0x0F, B=0x01, Cin=0, start at E0 -> done pulse after E8 only, S=0x10, Cout=0, V=0.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, V=0; A=0x7F, B=0x01 -> S=0x80, Cout=0, V=1; A=0x00, B=0x00, Cin=1 -> S=0x01.
- start held high across RUN with changing A/B -> first result unaffected, second operation accepted at E10 with operands present then.
- rst_n pulsed low mid-RUN (after E4) -> immediately busy=0, S=0; no done; next start computes correctly.
- SERIAL_ADDER_SUB_EN: sub=1, A=0x05, B=0x07 -> S=0xFE, Cout=0; A=0x80, B=0x01 -> S=0x7F, Cout=1, V=1.
- Back-to-back results: S from first op held unchanged throughout second op's RUN until its completion edge.
